// File: rtl/skinny_2shares_seq.sv
`default_nettype none
// ============================================================================
//  Module   : skinny_2shares_seq
//  Purpose  : Byte-stream sequencer for the 2-share SKINNY-128-384 core.
//             Commands and operand bytes arrive over a valid/ready byte link.
//             The block assembles the shared plaintext, shared TK3, TK1 and
//             TK2 registers, and pulses the core start. It then waits for
//             the core to finish, under a watchdog, and streams the shared
//             ciphertext back out MSB byte first.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT        watchdog limit in cycles, counted from core start
//    TO_W           watchdog counter width; must be able to hold TIMEOUT
//  Ports
//    clk_i          clock
//    rst_i          asynchronous reset, active low
//    rx_data_i      received byte
//    rx_valid_i     rx byte valid
//    rx_ready_o     rx byte accepted this cycle (IDLE / LOAD only)
//    tx_data_o      byte to transmit
//    tx_valid_o     tx byte valid (SEND only)
//    tx_ready_i     link accepts tx byte
//    core_input_o   shared plaintext {share1, share0}
//    core_key_o     shared TK3
//    core_tweak1_o  TK1 in [127:0], upper half driven 0
//    core_tweak2_o  TK2 in [127:0], upper half driven 0
//    core_start_o   one-cycle start pulse
//    core_done_i    core done flag (idles high, low while running)
//    core_cipher_i  core state / ciphertext
//    busy_o         FSM is not IDLE
//    err_o          sticky error (unknown command or watchdog expiry)
//  Build option
//    SKINNY_SEQ_RECOMBINE_EN : when defined, the two ciphertext shares are
//    XOR-recombined on capture and only the 16 unmasked bytes are sent.
// ============================================================================
module skinny_2shares_seq #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [7:0]   rx_data_i,
   input  logic         rx_valid_i,
   output logic         rx_ready_o,
   output logic [7:0]   tx_data_o,
   output logic         tx_valid_o,
   input  logic         tx_ready_i,
   output logic [255:0] core_input_o,
   output logic [255:0] core_key_o,
   output logic [255:0] core_tweak1_o,
   output logic [255:0] core_tweak2_o,
   output logic         core_start_o,
   input  logic         core_done_i,
   input  logic [255:0] core_cipher_i,
   output logic         busy_o,
   output logic         err_o
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam logic [7:0] c_CMD_INPUT  = 8'h01;
   localparam logic [7:0] c_CMD_KEY    = 8'h02;
   localparam logic [7:0] c_CMD_TWEAK1 = 8'h03;
   localparam logic [7:0] c_CMD_TWEAK2 = 8'h04;
   localparam logic [7:0] c_CMD_ENC    = 8'h10;
   localparam logic [7:0] c_CMD_CLRERR = 8'h20;

   localparam logic [4:0] c_LAST_WIDE   = 5'd31;   // 32-byte operands
   localparam logic [4:0] c_LAST_NARROW = 5'd15;   // 16-byte tweaks

`ifdef SKINNY_SEQ_RECOMBINE_EN
   localparam logic [4:0] c_TX_LAST = 5'd15;
`else
   localparam logic [4:0] c_TX_LAST = 5'd31;
`endif

   localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] c_WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_START   = 3'd2,
      S_WAIT_LO = 3'd3,
      S_WAIT_HI = 3'd4,
      S_SEND    = 3'd5
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t          r_state;
   logic [7:0]      r_cmd;
   logic [4:0]      r_cnt;
   logic [TO_W-1:0] r_wd;
   logic            r_err;
   logic [255:0]    r_pt;
   logic [255:0]    r_key;
   logic [127:0]    r_tk1;
   logic [127:0]    r_tk2;
   logic [255:0]    r_tx;

   // -------------------------------------------------------------------------
   // FSM control strobes
   // -------------------------------------------------------------------------
   state_t          w_state_nxt;
   logic            w_cmd_latch;
   logic            w_load_byte;
   logic            w_cnt_clr;
   logic            w_cnt_inc;
   logic            w_wd_clr;
   logic            w_wd_inc;
   logic            w_err_set;
   logic            w_err_clr;
   logic            w_tx_latch;
   logic            w_tx_shift;
   logic            w_load_last;
   logic            w_timeout;
   logic [255:0]    w_tx_capture;

   // Tweaks are half-width, so their loads end after 16 bytes.
   assign w_load_last = ((r_cmd == c_CMD_TWEAK1) || (r_cmd == c_CMD_TWEAK2))
                        ? (r_cnt == c_LAST_NARROW)
                        : (r_cnt == c_LAST_WIDE);

   assign w_timeout = (r_wd == c_TIMEOUT);

`ifdef SKINNY_SEQ_RECOMBINE_EN
   assign w_tx_capture = {core_cipher_i[255:128] ^ core_cipher_i[127:0], 128'h0};
`else
   assign w_tx_capture = core_cipher_i;
`endif

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_cmd_latch  = 1'b0;
      w_load_byte  = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_wd_clr     = 1'b0;
      w_wd_inc     = 1'b0;
      w_err_set    = 1'b0;
      w_err_clr    = 1'b0;
      w_tx_latch   = 1'b0;
      w_tx_shift   = 1'b0;

      // rx_ready is gated by reset so that every output reads 0 while the
      // block is held in reset.
      rx_ready_o   = rst_i && ((r_state == S_IDLE) || (r_state == S_LOAD));
      tx_valid_o   = (r_state == S_SEND);
      core_start_o = (r_state == S_START);
      busy_o       = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            if (rx_valid_i) begin
               case (rx_data_i)
                  c_CMD_INPUT, c_CMD_KEY, c_CMD_TWEAK1, c_CMD_TWEAK2: begin
                     w_cmd_latch = 1'b1;
                     w_cnt_clr   = 1'b1;
                     w_state_nxt = S_LOAD;
                  end
                  c_CMD_ENC:    w_state_nxt = S_START;
                  c_CMD_CLRERR: w_err_clr   = 1'b1;
                  default:      w_err_set   = 1'b1;
               endcase
            end
         end

         S_LOAD: begin
            if (rx_valid_i) begin
               w_load_byte = 1'b1;
               if (w_load_last) begin
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_inc   = 1'b1;
               end
            end
         end

         S_START: begin
            w_wd_clr    = 1'b1;
            w_state_nxt = S_WAIT_LO;
         end

         // done idles high; only a fall proves the core picked up the start,
         // so a stale high level here is never treated as completion.
         S_WAIT_LO: begin
            if (!core_done_i) begin
               w_wd_inc    = !w_timeout;
               w_state_nxt = S_WAIT_HI;
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_wd_inc    = 1'b1;
            end
         end

         // Completion wins over a watchdog expiry in the same cycle.
         S_WAIT_HI: begin
            if (core_done_i) begin
               w_tx_latch  = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_SEND;
            end else if (w_timeout) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_wd_inc    = 1'b1;
            end
         end

         S_SEND: begin
            if (tx_ready_i) begin
               w_tx_shift = 1'b1;
               if (r_cnt == c_TX_LAST) begin
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_inc   = 1'b1;
               end
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: counters, error flag, operand and tx shift registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_cmd <= '0;
         r_cnt <= '0;
         r_wd  <= '0;
         r_err <= 1'b0;
         r_pt  <= '0;
         r_key <= '0;
         r_tk1 <= '0;
         r_tk2 <= '0;
         r_tx  <= '0;
      end else begin
         if (w_cmd_latch) begin
            r_cmd <= rx_data_i;
         end

         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 5'd1;
         end

         if (w_wd_clr) begin
            r_wd <= '0;
         end else if (w_wd_inc) begin
            r_wd <= r_wd + c_WD_ONE;
         end

         if (w_err_clr) begin
            r_err <= 1'b0;
         end else if (w_err_set) begin
            r_err <= 1'b1;
         end

         // Bytes enter at the LSB, so the first byte received ends up in
         // the most significant byte once the load completes.
         if (w_load_byte) begin
            case (r_cmd)
               c_CMD_INPUT:  r_pt  <= {r_pt[247:0],  rx_data_i};
               c_CMD_KEY:    r_key <= {r_key[247:0], rx_data_i};
               c_CMD_TWEAK1: r_tk1 <= {r_tk1[119:0], rx_data_i};
               c_CMD_TWEAK2: r_tk2 <= {r_tk2[119:0], rx_data_i};
               default: ;
            endcase
         end

         // tx_data_o is the top byte; it only moves on an accepted transfer,
         // which keeps it stable while the link stalls.
         if (w_tx_latch) begin
            r_tx <= w_tx_capture;
         end else if (w_tx_shift) begin
            r_tx <= {r_tx[247:0], 8'h00};
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output mapping
   // -------------------------------------------------------------------------
   assign tx_data_o     = r_tx[255:248];
   assign core_input_o  = r_pt;
   assign core_key_o    = r_key;
   assign core_tweak1_o = {128'h0, r_tk1};
   assign core_tweak2_o = {128'h0, r_tk2};
   assign err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_skinny_2shares_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_skinny_2shares_seq
//  Purpose  : Scoreboard bench for skinny_2shares_seq with a behavioural
//             core model, randomized operands/ciphertexts and link stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_skinny_2shares_seq;

   localparam int TIMEOUT = 255;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         rx_ready_o;
   logic [7:0]   tx_data_o;
   logic         tx_valid_o;
   logic         tx_ready;
   logic [255:0] core_input_o;
   logic [255:0] core_key_o;
   logic [255:0] core_tweak1_o;
   logic [255:0] core_tweak2_o;
   logic         core_start_o;
   logic         core_done;
   logic [255:0] core_cipher;
   logic         busy_o;
   logic         err_o;

   skinny_2shares_seq #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rx_data_i     (rx_data),
      .rx_valid_i    (rx_valid),
      .rx_ready_o    (rx_ready_o),
      .tx_data_o     (tx_data_o),
      .tx_valid_o    (tx_valid_o),
      .tx_ready_i    (tx_ready),
      .core_input_o  (core_input_o),
      .core_key_o    (core_key_o),
      .core_tweak1_o (core_tweak1_o),
      .core_tweak2_o (core_tweak2_o),
      .core_start_o  (core_start_o),
      .core_done_i   (core_done),
      .core_cipher_i (core_cipher),
      .busy_o        (busy_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] sb[$];
   int         start_cnt = 0;
   int         forced_low = 0;
   bit         rand_stall = 1'b0;

   // Core model: 0 = normal, 1 = never drops done, 2 = drops but never rises
   int         core_mode = 0;
   int         core_lat = 56;
   int         core_cnt = 0;
   logic       done_rose = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Behavioural core
   // ------------------------------------------------------------------------
   initial core_done = 1'b1;
   always @(posedge clk_i) begin
      done_rose <= 1'b0;
      if (core_start_o) begin
         if (core_mode != 1) core_done <= 1'b0;
         core_cnt <= core_lat;
      end else if (!core_done && core_mode == 0) begin
         if (core_cnt <= 1) begin
            core_done <= 1'b1;
            done_rose <= 1'b1;
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // tx_ready driver: changes shortly after each rising edge
   // ------------------------------------------------------------------------
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk_i);
         #2;
         if (forced_low > 0) begin
            tx_ready = 1'b0;
            forced_low--;
         end else if (rand_stall) begin
            tx_ready = ($urandom_range(0, 3) != 0);
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor: pops the scoreboard on every transfer, checks stall stability
   // and the done-to-tx latency, and counts start pulses.
   // ------------------------------------------------------------------------
   logic       held_v = 1'b0;
   logic [7:0] held_d = 8'h00;
   logic       lat_pending = 1'b0;
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk_i);
         if (core_start_o) start_cnt++;
         if (lat_pending) begin
            check("tx_valid_after_done", tx_valid_o, 1);
            lat_pending = 1'b0;
         end
         if (done_rose && sb.size() > 0) begin
            check("tx_valid_before_done_seen", tx_valid_o, 0);
            lat_pending = 1'b1;
         end
         if (held_v && tx_valid_o) check("tx_data_stable", tx_data_o, held_d);
         held_v = tx_valid_o && !tx_ready;
         held_d = tx_data_o;
         if (tx_valid_o && tx_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL tx_unexpected: got byte %h expected none", tx_data_o);
            end else begin
               e = sb.pop_front();
               check("tx_byte", tx_data_o, e);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic send_byte(input logic [7:0] b, output int waits);
      waits = 0;
      @(negedge clk_i);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready_o && waits < 50) begin
         @(negedge clk_i);
         waits++;
      end
      if (waits >= 50) begin
         n_cmp++;
         n_err++;
         $display("FAIL rx_accept_timeout: got ready=0 expected ready=1");
      end
      @(posedge clk_i);
      #1 rx_valid = 1'b0;
   endtask

   // Sends val's top nbytes bytes (within the low 8*nbytes bits), MSB first.
   task automatic load_op(input logic [7:0] cmd, input logic [255:0] val, input int nbytes);
      int w;
      send_byte(cmd, w);
      for (int i = nbytes - 1; i >= 0; i--) send_byte(val[8*i +: 8], w);
   endtask

   task automatic wait_core_idle();
      int g = 0;
      while (!core_done && g < 500) begin
         @(negedge clk_i);
         g++;
      end
      check("core_model_idle", core_done, 1);
   endtask

   task automatic encrypt(input logic [255:0] cipher, input int lat, input bit mid_stall);
      int w;
      int s0;
      int g;
      logic [127:0] x;
      core_cipher = cipher;
      core_lat    = lat;
      core_mode   = 0;
`ifdef SKINNY_SEQ_RECOMBINE_EN
      x = cipher[255:128] ^ cipher[127:0];
      for (int i = 15; i >= 0; i--) sb.push_back(x[8*i +: 8]);
`else
      x = '0;
      for (int i = 31; i >= 0; i--) sb.push_back(cipher[8*i +: 8]);
`endif
      s0 = start_cnt;
      send_byte(8'h10, w);
      @(negedge clk_i);
      check("start_pulse", core_start_o, 1);
      @(negedge clk_i);
      check("start_one_cycle", core_start_o, 0);
      rx_data  = 8'h7E;
      rx_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("rx_ready_while_busy", rx_ready_o, 0);
         @(negedge clk_i);
      end
      rx_valid = 1'b0;
      if (mid_stall) begin
         g = 0;
         while (sb.size() > 20 && g < 1000) begin
            @(negedge clk_i);
            g++;
         end
         forced_low = 3;
      end
      g = 0;
      while ((sb.size() != 0 || busy_o) && g < 3000) begin
         @(negedge clk_i);
         g++;
      end
      check("encrypt_completes", (g < 3000), 1);
      check("start_count", start_cnt - s0, 1);
      check("err_after_encrypt", err_o, 0);
      check("idle_after_send", busy_o, 0);
      sb.delete();
   endtask

   task automatic encrypt_timeout(input int mode);
      int w;
      int cyc;
      core_mode = mode;
      core_lat  = 10;
      send_byte(8'h10, w);
      cyc = 0;
      while (!err_o && cyc < 400) begin
         @(negedge clk_i);
         cyc++;
      end
      check("wd_err_set", err_o, 1);
      check("wd_cycles_window", (cyc >= TIMEOUT && cyc <= TIMEOUT + 4), 1);
      check("wd_back_idle", busy_o, 0);
      check("wd_no_tx", tx_valid_o, 0);
      core_mode = 0;
      wait_core_idle();
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int w;
      logic [255:0] key_v;
      logic [255:0] t2_v;
      logic [255:0] v;
      rst_i       = 1'b1;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      core_cipher = '0;
      #2 rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      check("rst_tx_valid", tx_valid_o, 0);
      check("rst_start", core_start_o, 0);
      check("rst_input", core_input_o, 0);
      check("rst_key", core_key_o, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("idle_rx_ready", rx_ready_o, 1);

      // Plaintext load of 0x00..0x1F
      send_byte(8'h01, w);
      @(negedge clk_i);
      check("load_busy", busy_o, 1);
      for (int i = 0; i < 32; i++) begin
         send_byte(8'(i), w);
         check("load_rx_ready", w, 0);
      end
      @(negedge clk_i);
      check("load_done_idle", busy_o, 0);
      check("input_value", core_input_o,
            256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);

      // Key, TK1 (0xA5 pattern), TK2
      key_v = rand256();
      load_op(8'h02, key_v, 32);
      send_byte(8'h03, w);
      for (int i = 0; i < 16; i++) send_byte(8'hA5, w);
      t2_v = {128'h0, rand256() >> 128};
      load_op(8'h04, t2_v, 16);
      @(negedge clk_i);
      check("key_value", core_key_o, key_v);
      check("tweak1_value", core_tweak1_o, {128'h0, {16{8'hA5}}});
      check("tweak2_value", core_tweak2_o, t2_v);

      // Directed encryption with a mid-stream stall
      encrypt({{16{8'hFF}}, {16{8'h00}}}, 56, 1'b1);
      check("operands_held", core_key_o, key_v);

      // Randomized encryptions with random stalls and reloads
      rand_stall = 1'b1;
      for (int n = 0; n < 4; n++) begin
         v = rand256();
         load_op(8'h01, v, 32);
         @(negedge clk_i);
         check("rand_input", core_input_o, v);
         encrypt(rand256(), $urandom_range(3, 80), 1'b0);
      end
      rand_stall = 1'b0;

      // Watchdog: done never drops, then done drops but never rises
      encrypt_timeout(1);
      send_byte(8'h20, w);
      @(negedge clk_i);
      check("err_cleared", err_o, 0);
      encrypt_timeout(2);
      send_byte(8'h20, w);
      @(negedge clk_i);
      check("err_cleared_2", err_o, 0);

      // Unknown command
      send_byte(8'h7E, w);
      @(negedge clk_i);
      check("unknown_err", err_o, 1);
      check("unknown_idle", busy_o, 0);
      v = rand256();
      load_op(8'h01, v, 32);
      @(negedge clk_i);
      check("load_after_unknown", core_input_o, v);

      // Asynchronous reset mid key load
      send_byte(8'h02, w);
      for (int i = 0; i < 10; i++) send_byte(8'($urandom()), w);
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      check("arst_input", core_input_o, 0);
      check("arst_key", core_key_o, 0);
      check("arst_tk1", core_tweak1_o, 0);
      check("arst_tk2", core_tweak2_o, 0);
      check("arst_err", err_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_rx_ready", rx_ready_o, 0);
      check("arst_tx", {tx_valid_o, tx_data_o, core_start_o}, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      load_op(8'h02, {32{8'h11}}, 32);
      @(negedge clk_i);
      check("key_after_reset", core_key_o, {32{8'h11}});
      check("input_discarded", core_input_o, 0);

      repeat (5) @(negedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire

// File: doc/skinny_2shares_seq.md
Name: skinny_2shares_seq

Overview:
- Byte-stream sequencer for the 2-share SKINNY-128-384 encryption core; sits between the UART byte link and the core.
- Accepts command/data bytes, assembles the 256-bit shared plaintext, TK3 key, TK1 and TK2 operand registers, and pulses the core start.
- Waits for round completion with a watchdog, then streams the 256-bit shared ciphertext back out byte by byte.

Parameters:
- TIMEOUT, 255, max cycles allowed from core_start_o until core_done_i returns high.
- TO_W, 8, width of the watchdog counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  rx byte valid.
- rx_ready_o  out  1  block accepts rx byte this cycle.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx byte valid.
- tx_ready_i  in  1  link accepts tx byte.
- core_input_o  out  256  shared plaintext, {share1, share0}.
- core_key_o  out  256  shared TK3.
- core_tweak1_o  out  256  TK1; only [127:0] is meaningful, [255:128] driven 0.
- core_tweak2_o  out  256  TK2; only [127:0] is meaningful, [255:128] driven 0.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_done_i  in  1  core done flag. Idles high; goes low the cycle after start; returns high at the end.
- core_cipher_i  in  256  core state/ciphertext.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky error flag; cleared only by reset or command 0x20.

Behaviour:
- Reset (async, rst_i=0): all registers and outputs go to 0 and the FSM enters IDLE. This includes operand registers, counters, tx_valid_o, core_start_o and err_o. A reset mid-transfer discards the partial operand; no byte is replayed.
- Byte transfer: a byte moves when valid & ready are both high in the same cycle.
- rx_ready_o is 1 only in IDLE and LOAD. tx_valid_o is 1 only in SEND.
- Commands accepted in IDLE:
  - 0x01: load input.
  - 0x02: load key.
  - 0x03: load tweak1.
  - 0x04: load tweak2.
  - 0x10: encrypt.
  - 0x20: clear err_o.
  - Any other byte sets err_o and the FSM stays in IDLE.
- LOAD:
  - Byte count: 32 bytes for 0x01 and 0x02; 16 bytes for 0x03 and 0x04.
  - Each accepted byte shifts in from the LSB: reg <= {reg[W-9:0], rx_data_i}. The first byte received therefore ends in the top byte.
  - The byte counter is 5 bits. After the last byte, return to IDLE.
  - Operands hold their values across encryptions until reloaded.
- START: drive core_start_o=1 for exactly one cycle, clear the watchdog, go to WAIT_LO.
- WAIT_LO: wait for core_done_i=0, then go to WAIT_HI. A stale high done must not be taken as completion.
- WAIT_HI: when core_done_i=1, latch core_cipher_i into the tx shift register and go to SEND.
- Watchdog: it counts every cycle in WAIT_LO and WAIT_HI. When it reaches TIMEOUT, set err_o, go to IDLE and send nothing.
- SEND:
  - Bytes go out MSB first: tx_data_o = txreg[255:248].
  - On each transfer, shift txreg left by 8 and increment the counter.
  - tx_data_o must stay stable while tx_valid_o & !tx_ready_i.
  - After the 32nd transfer: tx_valid_o=0, go to IDLE.
- Latency: core_start_o asserts 1 cycle after the 0x10 byte is accepted. The first tx_valid_o asserts 1 cycle after core_done_i rises.
- Simultaneous rx_valid_i in non-accepting states: ignored and not acknowledged.

Optional Feature:
- Macro: SKINNY_SEQ_RECOMBINE_EN.
- Defined: in WAIT_HI, latch {share1 ^ share0, 128'h0}, i.e. core_cipher_i[255:128] ^ core_cipher_i[127:0]. SEND then emits only 16 bytes (unmasked ciphertext); this is for debug and known-answer testing.
- Undefined: both shares are sent, 32 bytes.

Test Plan:
- Reset, then send 0x01 plus 32 bytes 0x00..0x1F -> core_input_o = 256'h00010203...1E1F; rx_ready_o=1 throughout; busy_o falls after the last byte.
- Send 0x03 plus 16 bytes 0xA5 -> core_tweak1_o[127:0] = {16{8'hA5}}, [255:128] = 0; key unchanged.
- Load all operands, send 0x10, core model drops done 1 cycle after start and raises it 56 cycles later with cipher = 256'hFF..FF00..00 -> one start pulse; 32 tx bytes, 16×0xFF then 16×0x00. Hold tx_ready_i low for 3 cycles mid-stream -> tx_data_o stable.
- Send 0x10 with a core model that never drops done -> err_o=1 after 255 cycles, no tx_valid_o, FSM in IDLE. Then send 0x20 -> err_o=0.
- Send unknown byte 0x7E -> err_o=1, FSM stays in IDLE, next 0x01 load still works.
- Assert rst_i=0 after 10 bytes of a 0x02 load -> all outputs 0 immediately (async). After release, a fresh 0x02 with 32 bytes of 0x11 -> core_key_o = {32{8'h11}}.
